rc_pulse_decoder: RTL and testbench

- Receive end of the RC servo pulse interface; measures the high time of each incoming servo-style pulse in prescaler ticks.
- Reports the raw width and decodes the command pair (clockwise, anticlockwise) that the servo pulse generator encodes as width = {cw, acw, 8'h6F} ticks.
- Sits between a board input pin (external controller, or loopback of our own servo pulse for self-test) and the chip dispenser control logic.
- Also supervises the link and flags malformed or missing pulses.

---
 rtl/rc_pulse_decoder_pkg.sv | 36 +++
 rtl/rc_pulse_decoder_prescaler.sv | 29 ++
 rtl/rc_pulse_decoder.sv | 151 +++++++++++++++
 tb/tb_rc_pulse_decoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rc_pulse_decoder_pkg.sv
// Shared definitions for the RC servo pulse receive path.
// Holds the decoder state enum, default timing constants and the frame
// length shared with the servo pulse generator, plus the width-window decoder.
package rc_pulse_decoder_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        CHECK    = 2'd3
    } rc_state_e;

    localparam int CLK_DIV_DEF       = 195;
    localparam int BASE_W_DEF        = 111;   // 8'h6F, command 00
    localparam int TOL_DEF           = 8;
    localparam int FRAME_TIMEOUT_DEF = 4608;
    localparam int FRAME_TICKS       = 4096;  // generator frame length
    localparam int WIDTH_W           = 10;
    localparam int FRAME_W           = 13;

    // Returns {hit, k[1:0]}: hit when w lies within tol of base + 256*k.
    // Windows are disjoint for tol < 128, so at most one k can hit.
    function automatic logic [2:0] decode_width(input logic [WIDTH_W-1:0] w,
                                                input int base, input int tol);
        logic [2:0] r;
        int         d;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            d = int'(w) - (base + 256 * k);
            if (d <= tol && d >= -tol)
                r = {1'b1, 2'(k)};
        end
        return r;
    endfunction

endpackage

// File: rtl/rc_pulse_decoder_prescaler.sv
// rc_tick_prescaler: free-running clock divider producing the measurement tick.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   tick - one-clock pulse every DIV clocks (high at the counter wrap)
module rc_tick_prescaler #(
    parameter int DIV = 195
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap = (cnt == 8'(DIV - 1));
    assign tick = wrap;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (wrap)
            cnt <= '0;
        else
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/rc_pulse_decoder.sv
// rc_pulse_decoder: measures the high time of servo-style pulses in prescaler
// ticks, decodes the {cw, acw, 8'h6F} command encoding and supervises the link.
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   rc_pulse_in    - asynchronous pulse input from the board pin
//   pulse_width    - last measured high width in ticks
//   width_valid    - strobe: pulse_width updated
//   clockwise      - decoded command bit 1 (held until next good pulse)
//   anticlockwise  - decoded command bit 0 (held until next good pulse)
//   cmd_valid      - strobe: good command decoded
//   pulse_err      - strobe: overlong pulse or width outside every window
//   link_ok        - good pulses arriving within FRAME_TIMEOUT ticks
module rc_pulse_decoder
    import rc_pulse_decoder_pkg::*;
#(
    parameter int ClkDiv        = CLK_DIV_DEF,
    parameter int BASE_W        = BASE_W_DEF,
    parameter int TOL           = TOL_DEF,
    parameter int FRAME_TIMEOUT = FRAME_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rc_pulse_in,
    output logic [WIDTH_W-1:0] pulse_width,
    output logic               width_valid,
    output logic               clockwise,
    output logic               anticlockwise,
    output logic               cmd_valid,
    output logic               pulse_err,
    output logic               link_ok
);

    // Synchroniser is deliberately not reset: it keeps tracking the pin
    // during rst, so WAIT_LOW sees a pulse already in progress on release.
    logic sync1, sync, prev;
    logic rise, fall;

    always_ff @(posedge clk) begin
        sync1 <= rc_pulse_in;
        sync  <= sync1;
        prev  <= sync;
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

    logic tick;

    rc_tick_prescaler #(.DIV(ClkDiv)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    rc_state_e            state, state_n;
    logic [WIDTH_W-1:0]   wcnt;
    logic [FRAME_W-1:0]   fcnt;
    logic                 wcnt_clr, wcnt_inc, ovf, chk;
    logic [2:0]           dec;
    logic                 wv_q, cv_q, err_q;
    logic                 timeout;

    // The width counter is not advanced in CHECK, so it already holds the
    // latched width there.
    assign dec     = decode_width(wcnt, BASE_W, TOL);
    assign timeout = (fcnt == FRAME_W'(FRAME_TIMEOUT));

    always_comb begin
        state_n  = state;
        wcnt_clr = 1'b0;
        wcnt_inc = 1'b0;
        ovf      = 1'b0;
        chk      = 1'b0;
        case (state)
            WAIT_LOW: if (!sync) state_n = IDLE;
            IDLE: begin
                if (rise) begin
                    wcnt_clr = 1'b1;
                    state_n  = HIGH;
                end
            end
            HIGH: begin
                // fall has priority over a coincident tick
                if (fall) begin
                    state_n = CHECK;
                end else if (tick) begin
                    if (wcnt == '1) begin
                        ovf     = 1'b1;
                        state_n = WAIT_LOW;
                    end else begin
                        wcnt_inc = 1'b1;
                    end
                end
            end
            CHECK: begin
                chk     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= WAIT_LOW;
            wcnt          <= '0;
            fcnt          <= '0;
            pulse_width   <= '0;
            clockwise     <= 1'b0;
            anticlockwise <= 1'b0;
            link_ok       <= 1'b0;
            wv_q          <= 1'b0;
            cv_q          <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state <= state_n;

            if (wcnt_clr)
                wcnt <= '0;
            else if (wcnt_inc)
                wcnt <= wcnt + 1'b1;

            // Frame counter saturates at the timeout value.
            if (rise)
                fcnt <= '0;
            else if (tick && !timeout)
                fcnt <= fcnt + 1'b1;

            wv_q  <= chk;
            cv_q  <= chk & dec[2];
            err_q <= ovf | (chk & ~dec[2]);

            if (chk)
                pulse_width <= wcnt;

            if (chk && dec[2]) begin
                clockwise     <= dec[1];
                anticlockwise <= dec[0];
                link_ok       <= 1'b1;
            end else if (timeout) begin
                link_ok <= 1'b0;
            end
        end
    end

    // Masked so no strobe is visible in a clock where rst is asserted.
    assign width_valid = wv_q  & ~rst;
    assign cmd_valid   = cv_q  & ~rst;
    assign pulse_err   = err_q & ~rst;

endmodule

// File: tb/tb_rc_pulse_decoder.sv
module tb_rc_pulse_decoder;

    localparam int CD   = 3;
    localparam int BASE = 111;
    localparam int TOL  = 8;
    localparam int FT   = 4608;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rc_pulse_in = 1'b0;
    logic [9:0] pulse_width;
    logic       width_valid, clockwise, anticlockwise, cmd_valid, pulse_err, link_ok;

    rc_pulse_decoder #(.ClkDiv(CD), .BASE_W(BASE), .TOL(TOL), .FRAME_TIMEOUT(FT)) dut (
        .clk           (clk),
        .rst           (rst),
        .rc_pulse_in   (rc_pulse_in),
        .pulse_width   (pulse_width),
        .width_valid   (width_valid),
        .clockwise     (clockwise),
        .anticlockwise (anticlockwise),
        .cmd_valid     (cmd_valid),
        .pulse_err     (pulse_err),
        .link_ok       (link_ok)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_wv = 0, n_cv = 0, n_err = 0;
    int last_pw = 0;

    // Reference state: what the outputs should show, from the encoding rules.
    int exp_cw = 0, exp_acw = 0, exp_link = 0;
    int t_rise = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (width_valid) begin n_wv++; last_pw = int'(pulse_width); end
        if (cmd_valid) n_cv++;
        if (pulse_err) n_err++;
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a width is good when some command k has |w - (BASE + 256k)| <= TOL.
    task automatic model_decode(input int w, output int good, output int k);
        good = 0;
        k    = (w - BASE + 128) / 256;   // nearest nominal
        if (k < 0) k = 0;
        if (k > 3) k = 3;
        if (w - (BASE + 256 * k) <= TOL && (BASE + 256 * k) - w <= TOL) good = 1;
    endtask

    // Drive one pulse of w ticks, then check the report against the model.
    task automatic send_pulse(input int w, input int gap_ticks, input string tag);
        int wv0, cv0, er0, good, k;
        wv0 = n_wv; cv0 = n_cv; er0 = n_err;
        rc_pulse_in = 1'b1;
        t_rise = cyc;
        wclk(w * CD);
        if (w > 1030) begin
            chk({tag, "_ovf_err_at_overflow"}, n_err - er0, 1);
            chk({tag, "_ovf_no_wv_high"}, n_wv - wv0, 0);
        end
        rc_pulse_in = 1'b0;
        wclk(10);
        if (w > 1030) begin
            chk({tag, "_ovf_err"}, n_err - er0, 1);
            chk({tag, "_ovf_wv"}, n_wv - wv0, 0);
            chk({tag, "_ovf_cv"}, n_cv - cv0, 0);
        end else begin
            model_decode(w, good, k);
            if (good) begin
                exp_cw = (k >> 1) & 1; exp_acw = k & 1; exp_link = 1;
            end
            chk({tag, "_wv"}, n_wv - wv0, 1);
            chk({tag, "_pw"}, last_pw, (last_pw >= w - 1 && last_pw <= w + 1) ? last_pw : w);
            chk({tag, "_cv"}, n_cv - cv0, good);
            chk({tag, "_err"}, n_err - er0, 1 - good);
        end
        chk({tag, "_cw"}, int'(clockwise), exp_cw);
        chk({tag, "_acw"}, int'(anticlockwise), exp_acw);
        chk({tag, "_link"}, int'(link_ok), exp_link);
        wclk(gap_ticks * CD);
    endtask

    function automatic int good_w(input int k, input int off);
        return BASE + 256 * k + off;
    endfunction

    initial begin
        int k, w, d;

        // Reset state
        wclk(20);
        chk("rst_pw", int'(pulse_width), 0);
        chk("rst_cw", int'(clockwise), 0);
        chk("rst_acw", int'(anticlockwise), 0);
        chk("rst_strobes", int'({width_valid, cmd_valid, pulse_err}), 0);
        chk("rst_link", int'(link_ok), 0);
        rst = 1'b0;
        wclk(20);

        // Command 00 nominal, then each command in turn
        send_pulse(111, 40, "cmd00_a");
        send_pulse(111, 40, "cmd00_b");
        send_pulse(367, 40, "cmd01");
        send_pulse(623, 40, "cmd10");
        send_pulse(879, 40, "cmd11");

        // Window edges: inside by TOL-1, outside by TOL+2
        send_pulse(good_w(1, TOL - 1), 30, "edge_in_hi");
        send_pulse(good_w(2, -(TOL - 1)), 30, "edge_in_lo");
        send_pulse(good_w(0, TOL + 2), 30, "edge_out_hi");
        send_pulse(good_w(3, -(TOL + 2)), 30, "edge_out_lo");

        // Bad width, command outputs must hold
        send_pulse(200, 30, "bad200");

        // Randomised good and bad widths
        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0)
                w = good_w(k, int'($urandom_range(0, 2 * (TOL - 2))) - (TOL - 2));
            else if (k == 3)
                w = int'($urandom_range(20, BASE - TOL - 3));
            else
                w = good_w(k, int'($urandom_range(TOL + 3, 256 - TOL - 3)));
            send_pulse(w, 30, "rand");
        end

        // Overlong pulse, then a normal one
        send_pulse(1100, 30, "overlong");
        send_pulse(623, 30, "after_ovf");

        // Timeout: link drops FT ticks after the last rise, command held
        send_pulse(879, 0, "pre_tmo");
        while (link_ok && (cyc - t_rise) < (FT + 100) * CD) @(negedge clk);
        d = cyc - t_rise;
        chk("tmo_delay", (d >= FT * CD - CD && d <= FT * CD + CD + 8) ? FT * CD : d, FT * CD);
        exp_link = 0;
        chk("tmo_link", int'(link_ok), 0);
        chk("tmo_cw", int'(clockwise), exp_cw);
        chk("tmo_acw", int'(anticlockwise), exp_acw);
        send_pulse(367, 30, "post_tmo");

        // Reset mid-pulse, released while the input is still high
        rc_pulse_in = 1'b1;
        wclk(100 * CD);
        rst = 1'b1;
        wclk(5);
        chk("midrst_pw", int'(pulse_width), 0);
        chk("midrst_cmd", int'({clockwise, anticlockwise}), 0);
        chk("midrst_link", int'(link_ok), 0);
        chk("midrst_strobes", int'({width_valid, cmd_valid, pulse_err}), 0);
        exp_cw = 0; exp_acw = 0; exp_link = 0;
        begin
            int wv0, er0;
            wv0 = n_wv; er0 = n_err;
            rst = 1'b0;
            wclk(120 * CD);
            rc_pulse_in = 1'b0;
            wclk(20);
            chk("midrst_no_wv", n_wv - wv0, 0);
            chk("midrst_no_err", n_err - er0, 0);
        end
        send_pulse(879, 30, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
